// File: rtl/mac_accumulator_pkg.sv
// Shared constants and state type for the MAC accumulator slice.
package mac_accumulator_pkg;

    localparam int DATA_W = 16;
    localparam int PROD_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/mac_accumulator_requant_sat.sv
// Combinational requantizer: round-half-up, arithmetic shift, saturate to
// 16-bit signed. Optional ReLU clamp under MAC_ACCUMULATOR_RELU_EN.
module requant_sat
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int SHIFT = 8
) (
    input  logic signed [ACC_W-1:0]  sum,
    output logic signed [DATA_W-1:0] data,
    output logic                     sat
);

    // Half an output LSB; evaluates to zero when SHIFT is 0.
    localparam logic [ACC_W:0]        ONE  = 1;
    localparam logic signed [ACC_W:0] RND  = signed'((ONE << SHIFT) >> 1);
    localparam logic signed [ACC_W:0] QMAX = {{(ACC_W+1-DATA_W){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W:0] QMIN = {{(ACC_W+1-DATA_W){1'b1}}, SAT_MIN};

    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] q;

    // Round at one extra bit so the rounding add cannot wrap, then clip.
    always_comb begin
        r    = signed'({sum[ACC_W-1], sum}) + RND;
        q    = r >>> SHIFT;
        data = q[DATA_W-1:0];
        sat  = 1'b0;
        if (q > QMAX) begin
            data = SAT_MAX;
            sat  = 1'b1;
        end else if (q < QMIN) begin
            data = SAT_MIN;
            sat  = 1'b1;
        end
`ifdef MAC_ACCUMULATOR_RELU_EN
        if (data[DATA_W-1]) begin
            data = '0;
        end
`endif
    end

endmodule

// File: rtl/mac_accumulator.sv
// Packet dot-product accumulator with bias, requantization and a one-entry
// registered valid/ready output. Optional ReLU: MAC_ACCUMULATOR_RELU_EN.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int  ACC_W   = 40,
    parameter int  SHIFT   = 8,
    parameter int  MAX_LEN = 1024,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic signed [DATA_W-1:0] in_bias,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat,
    output logic                     err_len
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

    state_t                    state, state_nx;
    logic signed [ACC_W-1:0]   acc, acc_nx;
    logic [CNT_W-1:0]          cnt, cnt_nx;
    logic                      accept, finish, len_over;
    logic signed [DATA_W-1:0]  rq_data;
    logic                      rq_sat;

    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign finish   = accept && in_last;

    // Candidate accumulator/count after the current beat; the first beat
    // seeds the sum with the bias aligned to the fractional point.
    always_comb begin
        acc_nx   = acc;
        cnt_nx   = cnt;
        len_over = 1'b0;
        if (state == IDLE) begin
            acc_nx = (ACC_W'(in_bias) <<< SHIFT) + ACC_W'(in_prod);
            cnt_nx = CNT_W'(1);
        end else begin
            acc_nx   = acc + ACC_W'(in_prod);
            cnt_nx   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            len_over = (cnt == CNT_MAX) && !in_last;
        end
    end

    // Packet open/closed tracking.
    always_comb begin
        state_nx = state;
        if (accept) begin
            state_nx = in_last ? IDLE : ACCUM;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Accumulator, beat counter and sticky length error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            err_len <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_nx;
                cnt <= cnt_nx;
            end
            if (len_over) begin
                err_len <= 1'b1;
            end
        end
    end

    requant_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .sum  (acc_nx),
        .data (rq_data),
        .sat  (rq_sat)
    );

    // Output register: a new result loads even while the old one drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (finish) begin
            out_valid <= 1'b1;
            out_data  <= rq_data;
            out_sat   <= rq_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
